// File: rtl/setpoint_diff_pkg.sv
// Shared types and constants for the setpoint/measurement difference stage
// that feeds the 7-segment display decoder.
package setpoint_diff_pkg;

    localparam int MEAS_W = 5;
    localparam int DIFF_W = 4;
    localparam int SP_W   = 4;
    localparam int RES_W  = MEAS_W + 1;

    localparam logic [SP_W-1:0]   SP_MAX   = 4'd15;
    localparam logic [DIFF_W-1:0] DIFF_MAX = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPUTE = 2'd2
    } state_t;

endpackage

// File: rtl/setpoint_diff_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The counter tracks how many consecutive samples disagree with the
    // accepted level; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    level_reg <= sync2_reg;
                    press_reg <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/setpoint_diff.sv
// Setpoint register driven by debounced up/down buttons, plus a three-step
// FSM producing the saturated |meas - setpoint| and its sign for the display.
module setpoint_diff
    import setpoint_diff_pkg::*;
#(
    parameter int              DEBOUNCE_CYCLES = 4,
    parameter logic [SP_W-1:0] SP_RESET        = 4'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              sample,
    input  logic [MEAS_W-1:0] meas,
    output logic [SP_W-1:0]   setpoint,
    output logic [DIFF_W-1:0] diff,
    output logic              sinal,
    output logic              ovf,
    output logic              valid,
    output logic              busy
);

    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_down, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk  (clk),
                .rst  (rst),
                .btn  (btn_raw[gi]),
                .press(press[gi])
            );
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [SP_W-1:0]   sp_reg, sp_next;
    logic              sp_change;
    logic              sp_pend_reg, sp_pend_next;
    logic              smp_pend_reg, smp_pend_next;
    logic [MEAS_W-1:0] meas_cap_reg;
    logic [SP_W-1:0]   sp_used_reg;
    logic [DIFF_W-1:0] diff_reg;
    logic              sinal_reg, ovf_reg, valid_reg;
    logic [RES_W-1:0]  res, mag;

    // Simultaneous up and down presses cancel; limits swallow the press.
    always_comb begin
        sp_next   = sp_reg;
        sp_change = 1'b0;
        if (press[0] && !press[1] && sp_reg != SP_MAX) begin
            sp_next   = sp_reg + 1'b1;
            sp_change = 1'b1;
        end else if (press[1] && !press[0] && sp_reg != '0) begin
            sp_next   = sp_reg - 1'b1;
            sp_change = 1'b1;
        end
    end

    // A request arriving in the CAPTURE cycle survives the clear and is
    // serviced on the next pass.
    assign sp_pend_next  = (sp_pend_reg  && state_reg != CAPTURE) || sp_change;
    assign smp_pend_next = (smp_pend_reg && state_reg != CAPTURE) || sample;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sp_pend_reg || smp_pend_reg) state_next = CAPTURE;
            CAPTURE: state_next = COMPUTE;
            COMPUTE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign res = {1'b0, meas_cap_reg} - {2'b00, sp_used_reg};
    assign mag = res[RES_W-1] ? (RES_W'(0) - res) : res;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_reg       <= SP_RESET;
            sp_pend_reg  <= 1'b0;
            smp_pend_reg <= 1'b0;
            meas_cap_reg <= '0;
            sp_used_reg  <= '0;
            diff_reg     <= '0;
            sinal_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            sp_reg       <= sp_next;
            sp_pend_reg  <= sp_pend_next;
            smp_pend_reg <= smp_pend_next;
            valid_reg    <= 1'b0;
            if (state_reg == CAPTURE) begin
                if (smp_pend_reg) begin
                    meas_cap_reg <= meas;
                end
                sp_used_reg <= sp_reg;
            end
            if (state_reg == COMPUTE) begin
                sinal_reg <= res[RES_W-1];
                ovf_reg   <= (mag > RES_W'(DIFF_MAX));
                diff_reg  <= (mag > RES_W'(DIFF_MAX)) ? DIFF_MAX : mag[DIFF_W-1:0];
                valid_reg <= 1'b1;
            end
        end
    end

    assign setpoint = sp_reg;
    assign diff     = diff_reg;
    assign sinal    = sinal_reg;
    assign ovf      = ovf_reg;
    assign valid    = valid_reg;
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_setpoint_diff.sv
// Directed bench for setpoint_diff: latency, button handling, saturation,
// merged requests while busy and reset mid-computation.
module tb_setpoint_diff;

    localparam int DB   = 4;
    localparam int HOLD = DB + 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       sample = 1'b0;
    logic [4:0] meas = 5'd0;
    logic [3:0] setpoint;
    logic [3:0] diff;
    logic       sinal, ovf, valid, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cnt = 0;

    always #5 clk = ~clk;

    setpoint_diff #(
        .DEBOUNCE_CYCLES(DB),
        .SP_RESET       (4'd0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .sample  (sample),
        .meas    (meas),
        .setpoint(setpoint),
        .diff    (diff),
        .sinal   (sinal),
        .ovf     (ovf),
        .valid   (valid),
        .busy    (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Advance one clock and sample outputs 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (valid) valid_cnt++;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int seen = 0;
        for (int k = 0; k < max_cycles && seen == 0; k++) begin
            tick();
            if (valid) seen = 1;
        end
        check(tag, seen, 1);
    endtask

    task automatic do_sample(input logic [4:0] m);
        meas   = m;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        wait_valid("sample_valid", 8);
    endtask

    task automatic press_up();
        btn_up = 1'b1;
        repeat (HOLD) tick();
        btn_up = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic press_down();
        btn_down = 1'b1;
        repeat (HOLD) tick();
        btn_down = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic check_out(input string tag, input int d, input int s, input int o);
        check({tag, "_diff"}, diff, d);
        check({tag, "_sinal"}, sinal, s);
        check({tag, "_ovf"}, ovf, o);
    endtask

    initial begin
        int seen;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_setpoint", setpoint, 0);
        check_out("rst", 0, 0, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);

        // Latency: sample at edge N, valid after edge N+3
        meas   = 5'd9;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        check("lat_n1_valid", valid, 0);
        tick();
        check("lat_n2_valid", valid, 0);
        check("lat_n2_busy", busy, 1);
        tick();
        check("lat_n3_valid", valid, 0);
        tick();
        check("lat_n4_valid", valid, 1);
        check_out("meas9", 9, 0, 0);
        check("meas9_sp", setpoint, 0);
        tick();
        check("valid_one_cycle", valid, 0);
        check_out("hold", 9, 0, 0);

        // Three up presses, one pass each
        valid_cnt = 0;
        repeat (3) press_up();
        check("up3_passes", valid_cnt, 3);
        check("up3_sp", setpoint, 3);
        do_sample(5'd1);
        check_out("sp3_meas1", 2, 1, 0);

        // Overflow and zero difference at setpoint 2
        press_down();
        check("sp2", setpoint, 2);
        do_sample(5'd31);
        check_out("sp2_meas31", 15, 0, 1);
        do_sample(5'd2);
        check_out("sp2_meas2", 0, 0, 0);

        // Down saturation at 0, then up saturation at 15
        valid_cnt = 0;
        repeat (5) press_down();
        check("down_passes", valid_cnt, 2);
        check("down_sp", setpoint, 0);
        valid_cnt = 0;
        repeat (20) press_up();
        check("up20_passes", valid_cnt, 15);
        check("up20_sp", setpoint, 15);
        check_out("sp15_meas2", 13, 1, 0);

        // Bouncing with runs shorter than the debounce window
        valid_cnt = 0;
        btn_down = 1'b1; repeat (2) tick();
        btn_down = 1'b0; repeat (2) tick();
        btn_down = 1'b1; repeat (2) tick();
        btn_down = 1'b0; repeat (12) tick();
        check("bounce_sp", setpoint, 15);
        check("bounce_passes", valid_cnt, 0);

        // Both buttons in the same cycle cancel
        btn_up = 1'b1; btn_down = 1'b1;
        repeat (HOLD) tick();
        btn_up = 1'b0; btn_down = 1'b0;
        repeat (HOLD) tick();
        check("both_sp", setpoint, 15);
        check("both_passes", valid_cnt, 0);

        // Button-started pass; two samples arrive while busy and merge
        btn_down = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            tick();
            if (busy) seen = 1;
        end
        check("busy_seen", seen, 1);
        meas = 5'd5; sample = 1'b1;
        tick();
        check("busy_in_compute", busy, 1);
        meas = 5'd7; sample = 1'b1;
        tick();
        sample = 1'b0;
        check("pass1_valid", valid, 1);
        check_out("pass1", 12, 1, 0);
        wait_valid("pass2_valid", 8);
        check_out("pass2", 7, 1, 0);
        btn_down = 1'b0;
        repeat (HOLD) tick();
        check("sp14", setpoint, 14);

        // Reset while in COMPUTE aborts the pass
        meas = 5'd20; sample = 1'b1;
        tick();
        sample = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        valid_cnt = 0;
        tick();
        rst = 1'b0;
        check("abort_valid", valid, 0);
        check_out("abort", 0, 0, 0);
        check("abort_busy", busy, 0);
        check("abort_sp", setpoint, 0);
        repeat (6) tick();
        check("abort_no_valid", valid_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/setpoint_diff.md
Name: setpoint_diff

Overview:
- Sequential stage directly upstream of the 7-segment display decoder.
- Holds a 4-bit setpoint adjusted by debounced up/down push-buttons and samples a 5-bit measured value on request.
- Produces the registered magnitude `diff[3:0]` and sign `sinal` that the display decoder consumes.
- Magnitude saturates at 15; saturation is flagged on `ovf`.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples a button needs before its level is accepted (sim value; board build overrides it).
- SP_RESET, 0, setpoint value after reset (0..15).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- btn_up  in  1  raw, asynchronous setpoint-increment button, active-high
- btn_down  in  1  raw, asynchronous setpoint-decrement button, active-high
- sample  in  1  single-cycle request to capture `meas`
- meas  in  5  measured value, 0..31, stable while `sample` is high
- setpoint  out  4  current setpoint register
- diff  out  4  |captured meas - setpoint used|, saturated to 15
- sinal  out  1  1 when captured meas < setpoint used; 0 when equal or greater
- ovf  out  1  1 when true magnitude > 15
- valid  out  1  one-cycle pulse when `diff`/`sinal`/`ovf` are updated
- busy  out  1  high while the FSM is not in IDLE

Behaviour:
- **Reset** (`rst`=1 at a clock edge):
  - `setpoint` = SP_RESET; `diff`=0, `sinal`=0, `ovf`=0, `valid`=0, `busy`=0.
  - Captured meas = 0; pending flags cleared; FSM = IDLE; debouncers cleared to released.
  - Reset applies in any state and aborts a computation in progress without issuing `valid`.
- **Button synchronisation:** each button passes a 2-flop synchroniser, then a debouncer.
- **Debouncing:** the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples.
- **Press detection:** a press is the 0->1 edge of the debounced level, one pulse per press. Holding a button gives no auto-repeat.
- **Setpoint update:**
  - On an up press: `setpoint` += 1, saturating at 15.
  - On a down press: `setpoint` -= 1, saturating at 0.
  - Up and down presses in the same cycle: `setpoint` is unchanged and no recompute is requested.
  - A press that changes `setpoint` sets the `sp_pend` flag. A press at a limit (no change) does not set it.
- **Sample request:** `sample`=1 in any cycle sets `smp_pend`. A second request before service is merged into the first; only one is held.
- **FSM states:**
  - IDLE: `busy`=0. If `smp_pend` or `sp_pend` is set, go to CAPTURE next cycle.
  - CAPTURE: latch `meas` into the meas register if `smp_pend` is set; otherwise keep the previous captured meas. Latch `setpoint` as sp_used. Clear the flags being serviced. Next state: COMPUTE.
  - COMPUTE: form the 6-bit signed value captured_meas - sp_used and register the outputs (rules below). Next state: IDLE.
- **Output rules in COMPUTE:**
  - `sinal` = result<0.
  - magnitude = |result|, 0..31.
  - `diff` = min(magnitude, 15); `ovf` = magnitude>15.
  - `valid`=1 for exactly this one cycle.
- **Latency:** `sample` at cycle N (FSM idle) -> `valid` and new outputs visible at cycle N+3. The three cycles are: pend flag registered, CAPTURE, COMPUTE.
- **Requests while busy:** they set the pend flags. They are serviced on the next pass, which starts the cycle after returning to IDLE.
- **Setpoint change during CAPTURE/COMPUTE:** `setpoint` updates immediately. The current computation uses sp_used; the change is recomputed on the following pass.
- **Simultaneous sample and setpoint change in IDLE:** both are serviced in one pass, using the new `meas` and the new setpoint.
- **Output stability:** `diff`, `sinal` and `ovf` hold their values between `valid` pulses.

Decomposition:
- **Shared package:**
  - FSM state encoding: IDLE=2'd0, CAPTURE=2'd1, COMPUTE=2'd2.
  - SP_MAX = 15 and DIFF_MAX = 15.
  - Width constants: MEAS_W = 5, DIFF_W = 4.
- **Sub-module `btn_debounce`:**
  - Contains the synchroniser, the debounce counter and the rising-edge pulse.
  - Parameterised by DEBOUNCE_CYCLES.
  - Instantiated twice, once for up and once for down.

Test Plan:
- Reset, then `sample` with `meas`=9 -> `valid` at N+3; `diff`=9, `sinal`=0, `ovf`=0, `setpoint`=0.
- Three up presses held for ≥DEBOUNCE_CYCLES+2 cycles, then `sample` with `meas`=1 -> `setpoint`=3; `diff`=2, `sinal`=1, `ovf`=0; one extra `valid` per setpoint change.
- `setpoint`=2, `meas`=31 -> `diff`=15, `sinal`=0, `ovf`=1. Then `meas`=2 -> `diff`=0, `sinal`=0, `ovf`=0.
- 20 up presses from 0 -> `setpoint` stops at 15; presses 16..20 give no `valid`. Same check for down presses stopping at 0.
- Button bouncing 1-0-1 with runs shorter than DEBOUNCE_CYCLES -> no setpoint change. Both buttons pressed in the same cycle -> no change.
- Two `sample` pulses during `busy` (`meas`=5 then 7) -> second pass captures 7. `rst` asserted in COMPUTE -> no `valid`, all outputs 0 the next cycle.
